// File: rtl/systolic_pe_ws.sv
// Weight-stationary systolic MAC cell with shadow weight chain.
// Signed/unsigned operands, saturating or wrapping accumulation.
module systolic_pe_ws #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 20,
    parameter bit SIGNED     = 1'b1,
    parameter bit SATURATE   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clear,
    input  logic                  acc_local,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ACC_WIDTH-1:0]  psum_in,
    input  logic                  w_load,
    input  logic [DATA_WIDTH-1:0] w_in,
    input  logic                  w_swap,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ACC_WIDTH-1:0]  psum_out,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] w_out,
    output logic                  sat_flag
);
    localparam int PW = 2 * DATA_WIDTH;
    localparam int SW = ACC_WIDTH + 1;

    if (ACC_WIDTH < PW) begin : g_width_check
        $error("ACC_WIDTH must be at least 2*DATA_WIDTH");
    end

    logic [DATA_WIDTH-1:0] w_shadow_q;
    logic [DATA_WIDTH-1:0] w_active_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [ACC_WIDTH-1:0]  psum_q;
    logic [ACC_WIDTH-1:0]  psum_d;
    logic                  valid_q;
    logic                  sat_q;
    logic                  ovf;
    logic [PW-1:0]         dx;
    logic [PW-1:0]         wx;
    logic [PW-1:0]         prod;
    logic [ACC_WIDTH-1:0]  addend;
    logic [SW-1:0]         prod_x;
    logic [SW-1:0]         add_x;
    logic [SW-1:0]         sum;

    // Extend operands, multiply, add at one guard bit, then clamp or wrap
    always_comb begin
        dx     = {{DATA_WIDTH{SIGNED && data_in[DATA_WIDTH-1]}}, data_in};
        wx     = {{DATA_WIDTH{SIGNED && w_active_q[DATA_WIDTH-1]}}, w_active_q};
        prod   = dx * wx;
        prod_x = {{(SW-PW){SIGNED && prod[PW-1]}}, prod};
        addend = acc_local ? psum_q : psum_in;
        add_x  = {SIGNED && addend[ACC_WIDTH-1], addend};
        sum    = prod_x + add_x;
        if (SIGNED) begin
            ovf = sum[SW-1] ^ sum[SW-2];
        end else begin
            ovf = sum[SW-1];
        end
        psum_d = sum[ACC_WIDTH-1:0];
        if (ovf && SATURATE) begin
            if (!SIGNED) begin
                psum_d = {ACC_WIDTH{1'b1}};
            end else if (sum[SW-1]) begin
                psum_d = {1'b1, {(ACC_WIDTH-1){1'b0}}};
            end else begin
                psum_d = {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end
        end
    end

    // Weight chain shift and shadow-to-active swap
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_shadow_q <= '0;
            w_active_q <= '0;
        end else begin
            if (w_load) w_shadow_q <= w_in;
            if (w_swap) w_active_q <= w_shadow_q;
        end
    end

    // Beat pipeline register; clear drops the sum but not data_out
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q  <= '0;
            psum_q  <= '0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            if (in_valid) data_q <= data_in;
            if (clear) begin
                psum_q  <= '0;
                valid_q <= 1'b0;
                sat_q   <= 1'b0;
            end else begin
                valid_q <= in_valid;
                if (in_valid) begin
                    psum_q <= psum_d;
                    if (ovf) sat_q <= 1'b1;
                end
            end
        end
    end

    assign data_out  = data_q;
    assign psum_out  = psum_q;
    assign out_valid = valid_q;
    assign w_out     = w_shadow_q;
    assign sat_flag  = sat_q;
endmodule

// File: tb/tb_systolic_pe_ws.sv
// Bench for systolic_pe_ws: three configurations driven in lockstep
// against an arithmetic model, plus a three-cell weight chain.
module tb_systolic_pe_ws;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic        clear, acc_local, in_valid, w_load, w_swap;
    logic [7:0]  data_in, w_in;
    logic [19:0] psum_in;
    logic [7:0]  dout [3];
    logic [7:0]  wout [3];
    logic [19:0] ps [3];
    logic        ov [3];
    logic        sat [3];

    logic        cw_load;
    logic [7:0]  cw_in;
    logic [7:0]  c_wout [3];
    logic [7:0]  c_dout [3];
    logic [19:0] c_ps [3];
    logic        c_ov [3];
    logic        c_sat [3];

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    systolic_pe_ws #(.DATA_WIDTH(8), .ACC_WIDTH(20), .SIGNED(1'b1), .SATURATE(1'b1)) dut_ss (
        .clk(clk), .rstn(rstn), .clear(clear), .acc_local(acc_local),
        .in_valid(in_valid), .data_in(data_in), .psum_in(psum_in),
        .w_load(w_load), .w_in(w_in), .w_swap(w_swap),
        .data_out(dout[0]), .psum_out(ps[0]), .out_valid(ov[0]),
        .w_out(wout[0]), .sat_flag(sat[0]));

    systolic_pe_ws #(.DATA_WIDTH(8), .ACC_WIDTH(20), .SIGNED(1'b0), .SATURATE(1'b1)) dut_us (
        .clk(clk), .rstn(rstn), .clear(clear), .acc_local(acc_local),
        .in_valid(in_valid), .data_in(data_in), .psum_in(psum_in),
        .w_load(w_load), .w_in(w_in), .w_swap(w_swap),
        .data_out(dout[1]), .psum_out(ps[1]), .out_valid(ov[1]),
        .w_out(wout[1]), .sat_flag(sat[1]));

    systolic_pe_ws #(.DATA_WIDTH(8), .ACC_WIDTH(20), .SIGNED(1'b1), .SATURATE(1'b0)) dut_sw (
        .clk(clk), .rstn(rstn), .clear(clear), .acc_local(acc_local),
        .in_valid(in_valid), .data_in(data_in), .psum_in(psum_in),
        .w_load(w_load), .w_in(w_in), .w_swap(w_swap),
        .data_out(dout[2]), .psum_out(ps[2]), .out_valid(ov[2]),
        .w_out(wout[2]), .sat_flag(sat[2]));

    systolic_pe_ws chain0 (
        .clk(clk), .rstn(rstn), .clear(1'b0), .acc_local(1'b0),
        .in_valid(1'b0), .data_in(8'h00), .psum_in(20'h0),
        .w_load(cw_load), .w_in(cw_in), .w_swap(1'b0),
        .data_out(c_dout[0]), .psum_out(c_ps[0]), .out_valid(c_ov[0]),
        .w_out(c_wout[0]), .sat_flag(c_sat[0]));

    systolic_pe_ws chain1 (
        .clk(clk), .rstn(rstn), .clear(1'b0), .acc_local(1'b0),
        .in_valid(1'b0), .data_in(8'h00), .psum_in(20'h0),
        .w_load(cw_load), .w_in(c_wout[0]), .w_swap(1'b0),
        .data_out(c_dout[1]), .psum_out(c_ps[1]), .out_valid(c_ov[1]),
        .w_out(c_wout[1]), .sat_flag(c_sat[1]));

    systolic_pe_ws chain2 (
        .clk(clk), .rstn(rstn), .clear(1'b0), .acc_local(1'b0),
        .in_valid(1'b0), .data_in(8'h00), .psum_in(20'h0),
        .w_load(cw_load), .w_in(c_wout[1]), .w_swap(1'b0),
        .data_out(c_dout[2]), .psum_out(c_ps[2]), .out_valid(c_ov[2]),
        .w_out(c_wout[2]), .sat_flag(c_sat[2]));

    task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: cfg 0 signed/sat, cfg 1 unsigned/sat, cfg 2 signed/wrap.
    logic [7:0]  m_sh, m_act, m_do;
    logic        m_ov;
    logic [19:0] m_ps [3];
    logic        m_sat [3];

    function automatic logic [20:0] f_beat(int c, logic [7:0] d, logic [7:0] w,
                                           logic [19:0] a);
        longint p, ad, s, lo, hi;
        logic   o;
        if (c != 1) begin
            p  = longint'($signed(d)) * longint'($signed(w));
            ad = longint'($signed(a));
            lo = -(64'sd1 <<< 19);
            hi = (64'sd1 <<< 19) - 1;
        end else begin
            p  = longint'(d) * longint'(w);
            ad = longint'(a);
            lo = 0;
            hi = (64'sd1 <<< 20) - 1;
        end
        s = p + ad;
        o = (s < lo) || (s > hi);
        if (o && c != 2) s = (s > hi) ? hi : lo;
        return {o, s[19:0]};
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_sh  <= '0;
            m_act <= '0;
            m_do  <= '0;
            m_ov  <= 1'b0;
            for (int c = 0; c < 3; c++) begin
                m_ps[c]  <= '0;
                m_sat[c] <= 1'b0;
            end
        end else begin
            if (in_valid) m_do <= data_in;
            m_ov <= in_valid && !clear;
            for (int c = 0; c < 3; c++) begin
                logic [20:0] r;
                r = f_beat(c, data_in, m_act, acc_local ? m_ps[c] : psum_in);
                if (clear) begin
                    m_ps[c]  <= '0;
                    m_sat[c] <= 1'b0;
                end else if (in_valid) begin
                    m_ps[c] <= r[19:0];
                    if (r[20]) m_sat[c] <= 1'b1;
                end
            end
            if (w_swap) m_act <= m_sh;
            if (w_load) m_sh <= w_in;
        end
    end

    always @(negedge clk) begin
        if (chk_en && rstn) begin
            for (int c = 0; c < 3; c++) begin
                cmp($sformatf("psum[%0d]", c), 32'(ps[c]), 32'(m_ps[c]));
                cmp($sformatf("dout[%0d]", c), 32'(dout[c]), 32'(m_do));
                cmp($sformatf("valid[%0d]", c), 32'(ov[c]), 32'(m_ov));
                cmp($sformatf("sat[%0d]", c), 32'(sat[c]), 32'(m_sat[c]));
                cmp($sformatf("wout[%0d]", c), 32'(wout[c]), 32'(m_sh));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clear = 0; acc_local = 0; in_valid = 0; w_load = 0; w_swap = 0;
        data_in = 0; w_in = 0; psum_in = 0; cw_load = 0; cw_in = 0;
    endtask

    task automatic set_w(logic [7:0] w);
        idle(); w_load = 1; w_in = w; tick();
        idle(); w_swap = 1; tick();
        idle();
    endtask

    initial begin
        idle();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        chk_en = 1'b1;
        tick();
        cmp("rst psum", 32'(ps[0]), 32'h0);
        cmp("rst dout", 32'(dout[0]), 32'h0);
        cmp("rst valid", 32'(ov[0]), 32'h0);
        cmp("rst wout", 32'(wout[0]), 32'h0);
        cmp("rst sat", 32'(sat[0]), 32'h0);

        set_w(8'd3);
        in_valid = 1; data_in = 8'd5; psum_in = 20'd10; tick();
        cmp("uns psum", 32'(ps[1]), 32'd25);
        cmp("uns dout", 32'(dout[1]), 32'd5);
        cmp("uns valid", 32'(ov[1]), 32'd1);
        idle(); tick();
        cmp("uns valid low", 32'(ov[1]), 32'd0);
        cmp("uns hold", 32'(ps[1]), 32'd25);

        set_w(8'hFE);
        in_valid = 1; data_in = 8'd7; psum_in = 20'hFFFFC; tick();
        cmp("sgn psum", 32'(ps[0]), 32'hFFFEE);
        cmp("sgn dout", 32'(dout[0]), 32'd7);

        set_w(8'd2);
        w_load = 1; w_in = 8'd9; tick();
        idle(); in_valid = 1; data_in = 8'd4; w_swap = 1; tick();
        cmp("ovl pre", 32'(ps[0]), 32'd8);
        idle(); in_valid = 1; data_in = 8'd4; tick();
        cmp("ovl post", 32'(ps[0]), 32'd36);

        set_w(8'd1);
        clear = 1; tick();
        cmp("clr0 psum", 32'(ps[0]), 32'd0);
        idle(); acc_local = 1; in_valid = 1; data_in = 8'd10; tick();
        cmp("loc 10", 32'(ps[0]), 32'd10);
        data_in = 8'd20; tick();
        cmp("loc 30", 32'(ps[0]), 32'd30);
        data_in = 8'd30; tick();
        cmp("loc 60", 32'(ps[0]), 32'd60);
        idle(); clear = 1; tick();
        cmp("clr psum", 32'(ps[0]), 32'd0);
        cmp("clr valid", 32'(ov[0]), 32'd0);

        set_w(8'd127);
        in_valid = 1; data_in = 8'd127; psum_in = 20'h7FFFF; tick();
        cmp("sat psum", 32'(ps[0]), 32'h7FFFF);
        cmp("sat flag", 32'(sat[0]), 32'd1);
        cmp("wrap psum", 32'(ps[2]), 32'h83F00);
        cmp("wrap flag", 32'(sat[2]), 32'd1);
        cmp("uns nosat", 32'(sat[1]), 32'd0);
        idle(); tick(); tick();
        cmp("sat sticky", 32'(sat[0]), 32'd1);
        in_valid = 1; data_in = 8'd0; psum_in = 20'd5; tick();
        cmp("sat sticky2", 32'(sat[0]), 32'd1);
        cmp("sat small", 32'(ps[0]), 32'd5);
        idle(); clear = 1; tick();
        cmp("sat clr", 32'(sat[0]), 32'd0);

        idle();
        cw_load = 1; cw_in = 8'd1; tick();
        cw_in = 8'd2; tick();
        cw_in = 8'd3; tick();
        idle();
        cmp("chain0", 32'(c_wout[0]), 32'd3);
        cmp("chain1", 32'(c_wout[1]), 32'd2);
        cmp("chain2", 32'(c_wout[2]), 32'd1);
        cw_load = 1; cw_in = 8'd4;
        in_valid = 1; data_in = 8'd9; psum_in = 20'd1;
        #2 rstn = 1'b0;
        #1;
        cmp("arst chain0", 32'(c_wout[0]), 32'd0);
        cmp("arst chain1", 32'(c_wout[1]), 32'd0);
        cmp("arst chain2", 32'(c_wout[2]), 32'd0);
        cmp("arst psum", 32'(ps[0]), 32'd0);
        cmp("arst dout", 32'(dout[0]), 32'd0);
        cmp("arst valid", 32'(ov[0]), 32'd0);
        idle();
        @(negedge clk);
        rstn = 1'b1;
        tick();
        cmp("post rst valid", 32'(ov[0]), 32'd0);
        cmp("post rst chain", 32'(c_wout[0]), 32'd0);

        for (int i = 0; i < 600; i++) begin
            clear     = ($urandom_range(0, 15) == 0);
            acc_local = $urandom_range(0, 1) == 1;
            in_valid  = $urandom_range(0, 3) != 0;
            w_load    = $urandom_range(0, 2) == 0;
            w_swap    = $urandom_range(0, 3) == 0;
            data_in   = 8'($urandom);
            w_in      = 8'($urandom);
            psum_in   = 20'($urandom);
            tick();
        end
        idle();
        tick(); tick();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
